// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver that turns the serial stream on i_rx back into bytes and
//   buffers them in a small first-word-fall-through FIFO with valid/ready.
//   The default frame is 8N1. Defining UART_RX_PARITY_EN switches the frame
//   to 8E1: the PARITY state and the parity checker are built only then.
//
// Ports
//   clk           rising-edge clock
//   rstn          synchronous reset, active-low
//   i_rx          serial line, idle high, asynchronous to clk
//   o_data        FIFO head byte (8'h00 while the FIFO is empty)
//   o_valid       FIFO not empty
//   i_ready       consumer takes the head when o_valid & i_ready
//   o_frame_err   1-cycle pulse: stop bit sampled low
//   o_parity_err  1-cycle pulse: parity mismatch (always 0 without UART_RX_PARITY_EN)
//   o_overflow    1-cycle pulse: complete byte dropped because the FIFO was full
//   o_busy        receiver FSM not idle
module uart_rx_fifo #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overflow,
   output logic       o_busy
);

   localparam int CPB  = CLK_FREQ_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] C_MID  = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   // receiver registers
   logic          r_rx_meta;
   logic          r_rx_s;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          w_push;
   logic          w_frame_err;
   logic          r_frame_err;
   logic          r_overflow;
`ifdef UART_RX_PARITY_EN
   logic          r_par;
   logic          w_par_nxt;
   logic          w_parity_err;
   logic          r_parity_err;
`endif

   // FIFO
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wr;
   logic [AW:0]   r_rd;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_wr_en;
   logic          w_ovf;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rx_meta   <= 1'b1;
         r_rx_s      <= 1'b1;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_meta   <= i_rx;
         r_rx_s      <= r_rx_meta;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_frame_err <= w_frame_err;
         r_overflow  <= w_ovf;
`ifdef UART_RX_PARITY_EN
         r_par        <= w_par_nxt;
         r_parity_err <= w_parity_err;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt    = r_par;
      w_parity_err = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            // mid start bit: a line already back high was a glitch
            if (r_cnt == C_MID) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_rx_s;
               w_idx_nxt          = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt   = '0;
               w_par_nxt   = r_rx_s;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (r_par != ^r_shift) w_parity_err = 1'b1;
                  else                   w_push       = 1'b1;
`else
                  w_push = 1'b1;
`endif
               end else begin
                  // frame error takes precedence over any parity mismatch
                  w_frame_err = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FIFO: extra wrap bit on each pointer distinguishes full from empty
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = o_valid & i_ready;
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_ovf   = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + 1'b1;
         if (w_pop)   r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr[AW-1:0]] <= r_shift;
   end

   // storage is not reset, so the head is masked while empty
   assign o_valid     = ~w_empty;
   assign o_data      = o_valid ? r_mem[r_rd[AW-1:0]] : '0;
   assign o_frame_err = r_frame_err;
   assign o_overflow  = r_overflow;
   assign o_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (CPB=10, HALF=5, FIFO_DEPTH=4).
//   Frames are generated bit by bit; a queue holds the bytes the FIFO should
//   contain, and error pulses are counted against expected totals.
module tb_uart_rx_fifo;

   localparam int CLK_FREQ_HZ = 1_000_000;
   localparam int BAUD        = 100_000;
   localparam int DEPTH       = 4;
   localparam int CPB         = CLK_FREQ_HZ / BAUD;
   localparam int HALF        = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // start edge reaches the FSM 3 edges after the line drops, is confirmed
   // HALF edges later, and the stop bit is sampled NB-1 bit times after that
   localparam int PUSH_EDGE = 3 + HALF + CPB * (NB - 1);

   logic       clk = 1'b0;
   logic       rstn;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_frame_err;
   logic       o_parity_err;
   logic       o_overflow;
   logic       o_busy;

   uart_rx_fifo #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_parity_err(o_parity_err),
      .o_overflow  (o_overflow),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q[$];
   int exp_fe = 0, exp_pe = 0, exp_ov = 0;
   int cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
   bit mon_en = 1'b0;
   int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random each cycle

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // consumer side: head byte and valid against the model queue
   always @(negedge clk) begin
      if (mon_en) begin
         check("valid", 32'(o_valid), 32'(q.size() != 0));
         if (o_valid && q.size() != 0) begin
            check("data", 32'(o_data), 32'(q[0]));
            if (i_ready) void'(q.pop_front());
         end
         if (o_frame_err)  cnt_fe++;
         if (o_parity_err) cnt_pe++;
         if (o_overflow)   cnt_ov++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic line, bit force_rdy);
      i_rx = line;
      if (force_rdy)          i_ready = 1'b1;
      else if (rdy_mode == 2) i_ready = 1'($urandom_range(0, 1));
      else                    i_ready = (rdy_mode == 1);
      tick();
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) drive(1'b1, 1'b0);
   endtask

   // one frame; rdy_cyc forces i_ready for that cycle, abort_at stops early
   task automatic send(logic [7:0] d, bit stop, bit par_ok, int rdy_cyc, int abort_at);
      logic [NB-1:0] bits;
      bits = '0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
      bits[9] = (^d) ^ ~par_ok;
`endif
      bits[NB-1] = stop;
      for (int c = 0; c < NB * CPB; c++) begin
         if (c == abort_at) return;
         drive(bits[c / CPB], c == rdy_cyc);
         if (c + 1 == PUSH_EDGE) begin
            if (!stop)                 exp_fe++;
            else if (!par_ok)          exp_pe++;
            else if (q.size() < DEPTH) q.push_back(d);
            else                       exp_ov++;
         end
      end
   endtask

   task automatic check_counts(string tag, bit expect_empty);
      check({tag, "_frame_err"},  32'(cnt_fe), 32'(exp_fe));
      check({tag, "_parity_err"}, 32'(cnt_pe), 32'(exp_pe));
      check({tag, "_overflow"},   32'(cnt_ov), 32'(exp_ov));
      if (expect_empty) check({tag, "_drained"}, 32'(q.size()), 32'd0);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_valid"},  32'(o_valid),      32'd0);
      check({tag, "_data"},   32'(o_data),       32'd0);
      check({tag, "_busy"},   32'(o_busy),       32'd0);
      check({tag, "_fe"},     32'(o_frame_err),  32'd0);
      check({tag, "_pe"},     32'(o_parity_err), 32'd0);
      check({tag, "_ovf"},    32'(o_overflow),   32'd0);
   endtask

   initial begin
      rstn    = 1'b0;
      i_rx    = 1'b1;
      i_ready = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rstn   = 1'b1;
      mon_en = 1'b1;
      idle(5);

      // single clean frame
      rdy_mode = 1;
      send(8'h55, 1'b1, 1'b1, -1, -1);
      check("t1_busy_end", 32'(o_busy), 32'd0);
      idle(5);
      check_counts("t1", 1'b1);

      // short low glitch on an idle line
      repeat (3) drive(1'b0, 1'b0);
      repeat (2) drive(1'b1, 1'b0);
      check("t2_busy_glitch", 32'(o_busy), 32'd1);
      idle(10);
      check("t2_busy_idle", 32'(o_busy), 32'd0);
      check_counts("t2", 1'b1);

      // bad stop bit then a held-low line: exactly one frame error
      send(8'hA3, 1'b0, 1'b1, -1, -1);
      repeat (50) drive(1'b0, 1'b0);
      check("t3_busy_break", 32'(o_busy), 32'd1);
      idle(10);
      check("t3_busy_idle", 32'(o_busy), 32'd0);
      check_counts("t3a", 1'b1);
      send(8'h01, 1'b1, 1'b1, -1, -1);
      idle(5);
      check_counts("t3b", 1'b1);

      // fill with no consumer; fifth byte overflows
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h10 + i), 1'b1, 1'b1, -1, -1);
         idle(3);
      end
      check_counts("t4_full", 1'b0);
      check("t4_overflow_total", 32'(cnt_ov), 32'd1);
      rdy_mode = 1;
      idle(10);
      check_counts("t4_drain", 1'b1);

      // full FIFO with a pop in the push cycle of the fifth byte
      rdy_mode = 0;
      for (int i = 0; i < 4; i++) begin
         send(8'(8'h20 + i), 1'b1, 1'b1, -1, -1);
         idle(3);
      end
      send(8'h24, 1'b1, 1'b1, PUSH_EDGE - 1, -1);
      idle(3);
      check_counts("t5_full", 1'b0);
      check("t5_level", 32'(q.size()), 32'd4);
      rdy_mode = 1;
      idle(10);
      check_counts("t5_drain", 1'b1);

`ifdef UART_RX_PARITY_EN
      // parity mismatch drops the byte; matching parity delivers it
      send(8'h07, 1'b1, 1'b0, -1, -1);
      idle(5);
      check_counts("t6_bad", 1'b1);
      send(8'h07, 1'b1, 1'b1, -1, -1);
      idle(5);
      check_counts("t6_good", 1'b1);
`endif

      // reset in the middle of a frame
      send(8'h5A, 1'b1, 1'b1, -1, 45);
      check("rst_busy_before", 32'(o_busy), 32'd1);
      mon_en = 1'b0;
      rstn   = 1'b0;
      i_rx   = 1'b1;
      tick();
      check_zero("midreset");
      tick();
      rstn = 1'b1;
      q.delete();
      mon_en = 1'b1;
      idle(5);
      send(8'hC6, 1'b1, 1'b1, -1, -1);
      idle(5);
      check_counts("after_reset", 1'b1);

      // random traffic with a randomly stalling consumer
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         logic [7:0] d;
         bit         stop;
         bit         par_ok;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
         par_ok = ($urandom_range(0, 5) != 0);
`else
         par_ok = 1'b1;
`endif
         send(d, stop, par_ok, -1, -1);
         idle(stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12)));
      end
      rdy_mode = 1;
      idle(20);
      check_counts("random", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
